// File: rtl/cdb_arbiter_pkg.sv
// Shared project types for the completion data bus: ROB geometry, the CDB packet
// and the fixed mapping of execution units onto arbiter request lines.
package cdb_arbiter_pkg;

  localparam int ROBSZ = 32;
  localparam int RBW   = $clog2(ROBSZ);

  typedef struct packed {
    logic           en;
    logic [RBW-1:0] idx;
    logic           exc;
  } Cdb_pkt_t;

  localparam int UNIT_ALU0 = 0;
  localparam int UNIT_ALU1 = 1;
  localparam int UNIT_MUL  = 2;
  localparam int UNIT_LSU  = 3;
  localparam int UNIT_BRU  = 4;
  localparam int UNIT_CSR  = 5;
  localparam int NUM_UNITS = 6;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant and broadcast bundle between the execution units, the CDB arbiter
// and the ROB/reservation-station side.
interface cdb_arbiter_if #(
  parameter int NREQ = 6,
  parameter int NCDB = 4
);
  import cdb_arbiter_pkg::*;

  logic     [NREQ-1:0] req_valid;
  Cdb_pkt_t [NREQ-1:0] req_pkt;
  logic     [NREQ-1:0] req_ready;
  logic                flush;
  Cdb_pkt_t [NCDB-1:0] cdb_pkt;
  logic     [15:0]     stall_cnt;

  modport master (
    output req_valid, req_pkt, flush,
    input  req_ready, cdb_pkt, stall_cnt
  );

  modport slave (
    input  req_valid, req_pkt, flush,
    output req_ready, cdb_pkt, stall_cnt
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin finder: first set bit of mask at or after start, wrapping at N.
// Purely combinational; no state, no backpressure.
module rr_pick #(
  parameter int N  = 6,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] start,
  output logic          found,
  output logic [PW-1:0] sel
);

  // Scan from the far end so the position nearest start is written last and wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(start) + k) % N]) begin
        found = 1'b1;
        sel   = PW'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to NCDB unit completions per cycle (exceptions first, round-robin) onto a registered CDB.
// Grant to broadcast is one cycle; req_ready is the only backpressure and drops to zero on flush or reset.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = NUM_UNITS,
  parameter int NCDB = 4
) (
  input logic         clk,
  input logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  logic     [PW-1:0]             rr_ptr;
  logic     [PW-1:0]             rr_d;
  logic     [NREQ-1:0]           exc_vec;
  logic     [NREQ-1:0]           base_mask;
  logic     [NREQ-1:0]           ready;
  logic     [NCDB-1:0]           slot_found;
  logic     [NCDB-1:0][PW-1:0]   slot_sel;
  logic     [NCDB-1:0][NREQ-1:0] slot_gnt;
  Cdb_pkt_t [NCDB-1:0]           cdb_q;
  Cdb_pkt_t [NCDB-1:0]           cdb_d;
  logic     [15:0]               stall_q;
  logic                          stall_hit;

  always_comb begin
    exc_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      exc_vec[i] = bus.req_pkt[i].exc;
    end
  end

  assign base_mask = (rst_n && !bus.flush) ? bus.req_valid : '0;

  // Each slot picks from whatever earlier slots left over; exception requests shadow the rest.
  for (genvar s = 0; s < NCDB; s++) begin : g_slot
    logic [NREQ-1:0] rem_in;
    logic [NREQ-1:0] rem_exc;
    logic [NREQ-1:0] pick_mask;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rem_out;
    logic            found;
    logic [PW-1:0]   sel;

    if (s == 0) begin : g_first
      assign rem_in = base_mask;
    end else begin : g_next
      assign rem_in = g_slot[s-1].rem_out;
    end

    assign rem_exc   = rem_in & exc_vec;
    assign pick_mask = (|rem_exc) ? rem_exc : rem_in;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .mask  (pick_mask),
      .start (rr_ptr),
      .found (found),
      .sel   (sel)
    );

    assign gnt     = found ? (NREQ'(1) << sel) : '0;
    assign rem_out = rem_in & ~gnt;

    assign slot_found[s] = found;
    assign slot_sel[s]   = sel;
    assign slot_gnt[s]   = gnt;
  end

  always_comb begin
    ready = '0;
    for (int s = 0; s < NCDB; s++) begin
      ready = ready | slot_gnt[s];
    end
  end

  assign bus.req_ready = ready;

  // Found slots are contiguous from 0, so the last one found is the last in grant order.
  always_comb begin
    cdb_d = '0;
    rr_d  = rr_ptr;
    for (int s = 0; s < NCDB; s++) begin
      if (slot_found[s]) begin
        cdb_d[s].en  = 1'b1;
        cdb_d[s].idx = bus.req_pkt[slot_sel[s]].idx;
        cdb_d[s].exc = bus.req_pkt[slot_sel[s]].exc;
        rr_d = (slot_sel[s] == PW'(NREQ - 1)) ? '0 : slot_sel[s] + PW'(1);
      end
    end
  end

  assign stall_hit = !bus.flush && |(bus.req_valid & ~ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q   <= '0;
      rr_ptr  <= '0;
      stall_q <= '0;
    end else begin
      cdb_q  <= cdb_d;
      rr_ptr <= rr_d;
      if (stall_hit && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  // A flush also hides whatever was granted the cycle before it.
  always_comb begin
    bus.cdb_pkt = cdb_q;
    if (bus.flush) begin
      for (int s = 0; s < NCDB; s++) begin
        bus.cdb_pkt[s].en = 1'b0;
      end
    end
  end

  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: grant table, flush, reset-in-traffic and counter saturation.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam logic [2:0] E = 3'd7;   // empty slot marker

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(6), .NCDB(4)) bus ();
  cdb_arbiter #(.NREQ(6), .NCDB(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [5:0]      valid;
    logic [5:0]      exc;
    logic            flush;
    logic [5:0]      exp_ready;
    logic [3:0][2:0] exp_slot;   // unit granted into each slot, E = none
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] stall_exp = '0;

  function automatic logic [3:0][2:0] sl(input logic [2:0] a, b, c, d);
    logic [3:0][2:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic logic [RBW-1:0] unit_idx(input int u);
    return (u == 4) ? RBW'(15) : RBW'(u * 2 + 3);
  endfunction

  task automatic drive(input logic [5:0] v, input logic [5:0] e, input logic f);
    bus.req_valid = v;
    bus.flush     = f;
    for (int u = 0; u < 6; u++) begin
      bus.req_pkt[u].en  = 1'b1;
      bus.req_pkt[u].idx = unit_idx(u);
      bus.req_pkt[u].exc = e[u];
    end
  endtask

  task automatic check_ready(input string name, input logic [5:0] exp);
    n_cmp++;
    if (bus.req_ready !== exp) begin
      n_bad++;
      $display("FAIL %s: req_ready=%b expected %b", name, bus.req_ready, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic [15:0] exp);
    n_cmp++;
    if (bus.stall_cnt !== exp) begin
      n_bad++;
      $display("FAIL %s: stall_cnt=%h expected %h", name, bus.stall_cnt, exp);
    end
  endtask

  // masked: flush is high now, so only en=0 is required on every slot.
  task automatic check_cdb(input string name, input logic [3:0][2:0] slots,
                           input logic [5:0] exc, input logic masked);
    Cdb_pkt_t [3:0] expv;
    logic ok;
    ok = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (slots[s] == E || masked) begin
        expv[s] = '0;
      end else begin
        expv[s].en  = 1'b1;
        expv[s].idx = unit_idx(int'(slots[s]));
        expv[s].exc = exc[slots[s]];
      end
      if (masked) ok = ok && (bus.cdb_pkt[s].en === 1'b0);
      else        ok = ok && (bus.cdb_pkt[s] === expv[s]);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: cdb_pkt=%h expected %h (en-only=%0b)", name, bus.cdb_pkt, expv, masked);
    end
  endtask

  logic [3:0][2:0] prev_slots;
  logic [5:0]      prev_exc;

  initial begin
    //            valid       exc         flush  ready       slots
    vecs[0]  = '{6'b111111, 6'b000000, 1'b0, 6'b001111, sl(0, 1, 2, 3)};
    vecs[1]  = '{6'b111111, 6'b000000, 1'b0, 6'b110011, sl(4, 5, 0, 1)};
    vecs[2]  = '{6'b111111, 6'b000000, 1'b0, 6'b111100, sl(2, 3, 4, 5)};
    vecs[3]  = '{6'b111111, 6'b100000, 1'b0, 6'b100111, sl(5, 0, 1, 2)};
    vecs[4]  = '{6'b010000, 6'b000000, 1'b0, 6'b010000, sl(4, E, E, E)};
    vecs[5]  = '{6'b000000, 6'b000000, 1'b0, 6'b000000, sl(E, E, E, E)};
    vecs[6]  = '{6'b000011, 6'b000000, 1'b0, 6'b000011, sl(0, 1, E, E)};
    vecs[7]  = '{6'b111111, 6'b010010, 1'b0, 6'b011110, sl(4, 1, 2, 3)};
    vecs[8]  = '{6'b111111, 6'b000000, 1'b1, 6'b000000, sl(E, E, E, E)};
    vecs[9]  = '{6'b111111, 6'b000000, 1'b0, 6'b110011, sl(4, 5, 0, 1)};
    vecs[10] = '{6'b000100, 6'b000000, 1'b0, 6'b000100, sl(2, E, E, E)};
    vecs[11] = '{6'b000000, 6'b000000, 1'b1, 6'b000000, sl(E, E, E, E)};
    vecs[12] = '{6'b000000, 6'b000000, 1'b0, 6'b000000, sl(E, E, E, E)};
    vecs[13] = '{6'b111111, 6'b111111, 1'b0, 6'b111001, sl(3, 4, 5, 0)};
    vecs[14] = '{6'b100001, 6'b100000, 1'b0, 6'b100001, sl(5, 0, E, E)};
    vecs[15] = '{6'b001000, 6'b000000, 1'b0, 6'b001000, sl(3, E, E, E)};

    // Reset state with every unit requesting.
    drive(6'b111111, 6'b000000, 1'b0);
    #2;
    check_ready("reset_ready", 6'b000000);
    check_cdb("reset_cdb", sl(E, E, E, E), 6'b000000, 1'b0);
    check_stall("reset_stall", 16'h0000);
    drive(6'b000000, 6'b000000, 1'b0);
    #10 rst_n = 1'b1;

    prev_slots = sl(E, E, E, E);
    prev_exc   = '0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].valid, vecs[i].exc, vecs[i].flush);
      #1;
      check_ready($sformatf("row%0d_ready", i), vecs[i].exp_ready);
      check_cdb($sformatf("row%0d_cdb", i), prev_slots, prev_exc, vecs[i].flush);
      check_stall($sformatf("row%0d_stall", i), stall_exp);
      if (!vecs[i].flush && |(vecs[i].valid & ~vecs[i].exp_ready)) stall_exp++;
      prev_slots = vecs[i].exp_slot;
      prev_exc   = vecs[i].exc;
    end
    @(posedge clk);
    #1 drive(6'b000000, 6'b000000, 1'b0);
    #1;
    check_cdb("tail_cdb", prev_slots, prev_exc, 1'b0);
    check_stall("tail_stall", stall_exp);

    // Reset asserted mid-cycle while grants 4,5,0,1 are pending: they are lost.
    @(posedge clk);
    #1 drive(6'b111111, 6'b000000, 1'b0);
    #1 check_ready("pre_rst_ready", 6'b110011);
    #2 rst_n = 1'b0;
    #1;
    check_ready("midrst_ready", 6'b000000);
    check_cdb("midrst_cdb", sl(E, E, E, E), 6'b000000, 1'b0);
    check_stall("midrst_stall", 16'h0000);
    @(posedge clk);
    #1;
    check_cdb("inrst_cdb", sl(E, E, E, E), 6'b000000, 1'b0);
    #1 rst_n = 1'b1;
    #1 check_ready("postrst_ready", 6'b001111);
    @(posedge clk);
    #1;
    check_cdb("postrst_cdb", sl(0, 1, 2, 3), 6'b000000, 1'b0);
    check_stall("postrst_stall", 16'h0001);
    check_ready("postrst_ready2", 6'b110011);

    // Continuous contention long enough to pin the counter at its ceiling.
    repeat (70000) @(posedge clk);
    #1 check_stall("sat_stall", 16'hFFFF);
    @(posedge clk);
    #1 check_stall("sat_hold", 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
